// File: rtl/strobe_sched_defs.sv
// Shared definitions for the strobe scheduler.
//   state_e : scheduler FSM encodings (IDLE / START / WAIT).
//             Encoding 2'd3 is unused and recovers to IDLE.
package strobe_sched_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/strobe.sv
// Single-channel edge detector. It turns a request level into a strobe that
// lasts one cycle.
//   clk        in  : system clock
//   reset      in  : synchronous, active-high
//   sig_in     in  : request level
//   strobe_out out : combinational, high in the same cycle the qualifying
//                    edge is seen on sig_in
// FLAG_CHANGE=0 fires on rising edges only. FLAG_CHANGE=1 fires on any toggle.
// RESET_ZERO=0 loads the live input into the history flop during reset.
// A level held high through reset then produces no strobe after release.
module strobe #(
    parameter int FLAG_CHANGE = 0,
    parameter int RESET_ZERO  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic strobe_out
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig_in;
        if (reset && (RESET_ZERO != 0)) begin
            prev_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        prev_q <= prev_d;
    end

    always_comb begin
        strobe_out = 1'b0;
        if (!reset) begin
            if (FLAG_CHANGE != 0) begin
                strobe_out = sig_in ^ prev_q;
            end else begin
                strobe_out = sig_in & ~prev_q;
            end
        end
    end

endmodule

// File: rtl/strobe_scheduler.sv
// Round-robin scheduler. It shares one downstream processor between
// NUM_CHANNELS requesting channels.
//   clk           in  : system clock
//   reset         in  : synchronous, active-high
//   req_in        in  : per-channel request level; edges become pending jobs
//   done_in       in  : 1-cycle pulse, the processor has finished the current job
//   clear_overrun in  : clears the sticky overrun and timeout flags
//   start_out     out : 1-cycle pulse, begin the job for chan_out
//   chan_out      out : channel being serviced; holds its last value in IDLE
//   busy_out      out : high in START and WAIT
//   overrun_out   out : sticky, a request arrived while already pending
//   timeout_out   out : sticky, a job was aborted after TIMEOUT_CYCLES in WAIT
module strobe_scheduler
    import strobe_sched_defs::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int CHAN_BITS      = 2,
    parameter int FLAG_CHANGE    = 0,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TIMEOUT_BITS   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] req_in,
    input  logic                    done_in,
    input  logic                    clear_overrun,
    output logic                    start_out,
    output logic [CHAN_BITS-1:0]    chan_out,
    output logic                    busy_out,
    output logic [NUM_CHANNELS-1:0] overrun_out,
    output logic                    timeout_out
);

    // Returns the first set bit of pend, scanning from last+1 and wrapping.
    // It is only used when pend is non-zero.
    function automatic logic [CHAN_BITS-1:0] rr_pick(
        input logic [NUM_CHANNELS-1:0] pend,
        input logic [CHAN_BITS-1:0]    last
    );
        logic [CHAN_BITS-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = last;
        found = 1'b0;
        for (int off = 1; off <= NUM_CHANNELS; off++) begin
            idx = int'(last) + off;
            if (idx >= NUM_CHANNELS) begin
                idx = idx - NUM_CHANNELS;
            end
            if (!found && pend[idx[CHAN_BITS-1:0]]) begin
                pick  = idx[CHAN_BITS-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // ---------------- request edge detection ----------------
    logic [NUM_CHANNELS-1:0] strobe_w;

    generate
        for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_strobe
            strobe #(
                .FLAG_CHANGE (FLAG_CHANGE),
                .RESET_ZERO  (0)
            ) u_strobe (
                .clk        (clk),
                .reset      (reset),
                .sig_in     (req_in[i]),
                .strobe_out (strobe_w[i])
            );
        end
    endgenerate

    // ---------------- state ----------------
    state_e                  state_q,   state_d;
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [NUM_CHANNELS-1:0] overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;
    logic [CHAN_BITS-1:0]    chan_q,    chan_d;
    logic [CHAN_BITS-1:0]    last_q,    last_d;
    logic [TIMEOUT_BITS-1:0] cnt_q,     cnt_d;

    logic                    grant_w;
    logic [CHAN_BITS-1:0]    pick_w;
    logic                    timeout_set;

    assign pick_w  = rr_pick(pending_q, last_q);
    assign grant_w = (state_q == ST_IDLE) && (pending_q != '0);

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // done_in is deliberately ignored here
                if (grant_w) begin
                    chan_d  = pick_w;
                    last_d  = pick_w;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (done_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = TIMEOUT_BITS'(1);
                end
            end
            ST_WAIT: begin
                if (done_in) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_BITS'(TIMEOUT_CYCLES)) begin
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- pending / sticky flags ----------------
    // When a new strobe and a grant hit the same channel in one cycle, the
    // set wins and no overrun is flagged. New events also win over
    // clear_overrun.
    always_comb begin
        pending_d = pending_q;
        overrun_d = clear_overrun ? '0 : overrun_q;
        timeout_d = (clear_overrun ? 1'b0 : timeout_q) | timeout_set;
        if (grant_w) begin
            pending_d[pick_w] = 1'b0;
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (strobe_w[i]) begin
                if (pending_q[i] && !(grant_w && (pick_w == CHAN_BITS'(i)))) begin
                    overrun_d[i] = 1'b1;
                end
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            overrun_q <= '0;
            timeout_q <= 1'b0;
            chan_q    <= '0;
            // start one below channel 0 so that channel 0 wins first
            last_q    <= CHAN_BITS'(NUM_CHANNELS - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            chan_q    <= chan_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    // ---------------- outputs ----------------
    assign start_out   = (state_q == ST_START);
    assign busy_out    = (state_q != ST_IDLE);
    assign chan_out    = chan_q;
    assign overrun_out = overrun_q;
    assign timeout_out = timeout_q;

endmodule
